bp_be_fe_cmd_scheduler: RTL and testbench



---
 rtl/bp_be_fe_cmd_scheduler.sv | 142 ++++++++++++++
 tb/tb_bp_be_fe_cmd_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fe_cmd_scheduler.sv
// FE command scheduler.
// Three BE command sources (redirect/trap, itlb fill, icache/tlb fence) are
// merged by fixed priority into a small circular FIFO and issued to the FE.
// Once a fence-class entry has been issued, issue is held off until the FE
// drops fe_cmd_fence_i.
//
// Handshake rule used on every port pair: a transfer happens on a rising
// clk_i edge exactly when valid and ready are both 1 during that cycle.
// Valid never waits on ready. The FE-side valid is a function of registered
// state only. Each requester's ready is combinational from the requester
// valids, the FIFO count and the same-cycle dequeue credit.
module bp_be_fe_cmd_scheduler #(
  parameter int fe_cmd_width_p = 128,
  parameter int els_p          = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,

  input  logic [fe_cmd_width_p-1:0] redirect_cmd_i,
  input  logic                      redirect_v_i,
  output logic                      redirect_ready_o,

  input  logic [fe_cmd_width_p-1:0] itlb_cmd_i,
  input  logic                      itlb_v_i,
  output logic                      itlb_ready_o,

  input  logic [fe_cmd_width_p-1:0] fence_cmd_i,
  input  logic                      fence_v_i,
  output logic                      fence_ready_o,

  output logic [fe_cmd_width_p-1:0] fe_cmd_o,
  output logic                      fe_cmd_v_o,
  input  logic                      fe_cmd_ready_i,
  input  logic                      fe_cmd_fence_i,

  output logic                      busy_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  typedef enum logic {
    e_run  = 1'b0,
    e_wait = 1'b1
  } state_e;

  state_e                    state_r;
  logic [fe_cmd_width_p-1:0] cmd_mem [els_p];
  logic [els_p-1:0]          fence_mem;
  logic [ptr_w-1:0]          rptr_r;
  logic [ptr_w-1:0]          wptr_r;
  logic [cnt_w-1:0]          count_r;

  logic                      full;
  logic                      deq;
  logic                      deq_fence;
  logic                      space;
  logic                      enq;
  logic [fe_cmd_width_p-1:0] enq_cmd;
  logic                      enq_fence;
  logic [ptr_w-1:0]          wr_idx;

  assign full       = (count_r == cnt_w'(els_p));
  assign fe_cmd_v_o = (count_r != '0) && (state_r == e_run);
  assign fe_cmd_o   = cmd_mem[rptr_r];
  assign busy_o     = (count_r != '0) || (state_r == e_wait);

  assign deq        = fe_cmd_v_o && fe_cmd_ready_i;
  assign deq_fence  = deq && fence_mem[rptr_r];

  // A flush empties the FIFO this edge, so a redirect always finds room then.
  assign space      = !full || deq || flush_i;

  assign redirect_ready_o = !reset_i && space;
  assign itlb_ready_o     = !reset_i && !flush_i && space && !redirect_v_i;
  assign fence_ready_o    = !reset_i && !flush_i && space && !redirect_v_i && !itlb_v_i;

  // Pick the single winning source for this cycle's enqueue.
  always_comb begin
    enq       = 1'b0;
    enq_cmd   = redirect_cmd_i;
    enq_fence = 1'b0;
    if (redirect_v_i && redirect_ready_o) begin
      enq       = 1'b1;
      enq_cmd   = redirect_cmd_i;
    end else if (itlb_v_i && itlb_ready_o) begin
      enq       = 1'b1;
      enq_cmd   = itlb_cmd_i;
    end else if (fence_v_i && fence_ready_o) begin
      enq       = 1'b1;
      enq_cmd   = fence_cmd_i;
      enq_fence = 1'b1;
    end
  end

  // After a flush the surviving redirect lands in slot 0 of the emptied FIFO.
  assign wr_idx = flush_i ? '0 : wptr_r;

  // Entry storage: data only, no reset needed since count gates validity.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      cmd_mem[wr_idx]   <= enq_cmd;
      fence_mem[wr_idx] <= enq_fence;
    end
  end

  // Pointers, occupancy and the RUN/WAIT issue state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
      state_r <= e_run;
    end else if (flush_i) begin
      rptr_r  <= '0;
      wptr_r  <= enq ? ptr_w'(1) : '0;
      count_r <= enq ? cnt_w'(1) : '0;
      // The FE already took a fence in this cycle, so the stall still applies.
      state_r <= deq_fence ? e_wait : e_run;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_w'(1);
      if (deq) rptr_r <= rptr_r + ptr_w'(1);
      count_r <= count_r + cnt_w'(enq) - cnt_w'(deq);
      case (state_r)
        e_run:   if (deq_fence) state_r <= e_wait;
        e_wait:  if (!fe_cmd_fence_i) state_r <= e_run;
        default: state_r <= e_run;
      endcase
    end
  end

  a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i)
    (enq && full) |-> (deq || flush_i));

  a_no_deq_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    deq |-> (count_r != '0));

  a_head_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (fe_cmd_v_o && !fe_cmd_ready_i && !flush_i) |=> $stable(fe_cmd_o));

endmodule

// File: tb/tb_bp_be_fe_cmd_scheduler.sv
// Bench for bp_be_fe_cmd_scheduler: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_bp_be_fe_cmd_scheduler;

  localparam int W   = 128;
  localparam int ELS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i = 1'b1;
  logic         flush_i = 1'b0;
  logic [W-1:0] redirect_cmd_i = '0;
  logic         redirect_v_i = 1'b0;
  logic         redirect_ready_o;
  logic [W-1:0] itlb_cmd_i = '0;
  logic         itlb_v_i = 1'b0;
  logic         itlb_ready_o;
  logic [W-1:0] fence_cmd_i = '0;
  logic         fence_v_i = 1'b0;
  logic         fence_ready_o;
  logic [W-1:0] fe_cmd_o;
  logic         fe_cmd_v_o;
  logic         fe_cmd_ready_i = 1'b0;
  logic         fe_cmd_fence_i = 1'b0;
  logic         busy_o;

  bp_be_fe_cmd_scheduler #(.fe_cmd_width_p(W), .els_p(ELS)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (flush_i),
    .redirect_cmd_i   (redirect_cmd_i),
    .redirect_v_i     (redirect_v_i),
    .redirect_ready_o (redirect_ready_o),
    .itlb_cmd_i       (itlb_cmd_i),
    .itlb_v_i         (itlb_v_i),
    .itlb_ready_o     (itlb_ready_o),
    .fence_cmd_i      (fence_cmd_i),
    .fence_v_i        (fence_v_i),
    .fence_ready_o    (fence_ready_o),
    .fe_cmd_o         (fe_cmd_o),
    .fe_cmd_v_o       (fe_cmd_v_o),
    .fe_cmd_ready_i   (fe_cmd_ready_i),
    .fe_cmd_fence_i   (fe_cmd_fence_i),
    .busy_o           (busy_o)
  );

  // ---------------- scoreboard state ----------------
  // Each entry: {fence flag, command}.
  logic [W:0] exp_q[$];
  bit         waiting = 1'b0;
  bit         armed   = 1'b0;
  int         n_cmp   = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  function automatic logic [W-1:0] rnd_cmd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Holds one set of inputs for one full cycle (called at a negedge).
  task automatic drive(input bit rv, input bit iv, input bit fv, input bit fr,
                       input bit fi, input bit fl, input bit rs);
    reset_i        = rs;
    flush_i        = fl;
    redirect_v_i   = rv;
    itlb_v_i       = iv;
    fence_v_i      = fv;
    redirect_cmd_i = rnd_cmd();
    itlb_cmd_i     = rnd_cmd();
    fence_cmd_i    = rnd_cmd();
    fe_cmd_ready_i = fr;
    fe_cmd_fence_i = fi;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Checks ready/valid/busy at negedge+1 and updates the expected queue at
  // negedge+3, after the monitor has popped this cycle's issued command.
  bit         m_deq_fence;
  int         m_acc;          // 0 none, 1 redirect, 2 itlb, 3 fence
  logic [W-1:0] m_acc_cmd;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      begin
        int  size;
        bit  exp_v, exp_deq, space, exp_rr, exp_ir, exp_fr;
        size    = exp_q.size();
        exp_v   = (size != 0) && !waiting;
        exp_deq = exp_v && fe_cmd_ready_i;
        m_deq_fence = exp_deq && exp_q[0][W];
        space   = !reset_i && (size < ELS || exp_deq || flush_i);
        exp_rr  = space;
        exp_ir  = space && !flush_i && !redirect_v_i;
        exp_fr  = space && !flush_i && !redirect_v_i && !itlb_v_i;
        chk("redirect_ready", W'(redirect_ready_o), W'(exp_rr));
        chk("itlb_ready",     W'(itlb_ready_o),     W'(exp_ir));
        chk("fence_ready",    W'(fence_ready_o),    W'(exp_fr));
        if (armed) begin
          chk("fe_cmd_v", W'(fe_cmd_v_o), W'(exp_v));
          chk("busy",     W'(busy_o),     W'((size != 0) || waiting));
        end
        m_acc = 0;
        m_acc_cmd = '0;
        if (redirect_v_i && exp_rr)    begin m_acc = 1; m_acc_cmd = redirect_cmd_i; end
        else if (itlb_v_i && exp_ir)   begin m_acc = 2; m_acc_cmd = itlb_cmd_i; end
        else if (fence_v_i && exp_fr)  begin m_acc = 3; m_acc_cmd = fence_cmd_i; end
      end
      #2;
      if (reset_i) begin
        exp_q.delete();
        waiting = 1'b0;
        armed   = 1'b1;
      end else begin
        if (flush_i) begin
          exp_q.delete();
          waiting = m_deq_fence;
        end else if (!waiting) begin
          waiting = m_deq_fence;
        end else if (!fe_cmd_fence_i) begin
          waiting = 1'b0;
        end
        if (m_acc != 0) exp_q.push_back({(m_acc == 3), m_acc_cmd});
      end
    end
  end

  // ---------------- monitor ----------------
  // Pops the expected queue whenever the DUT completes an FE handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (armed && fe_cmd_v_o === 1'b1 && fe_cmd_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", W'(fe_cmd_v_o), W'(0));
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("fe_cmd", fe_cmd_o, e[W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset for two cycles.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Priority: all three request at once on an empty FIFO.
    drive(1, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 0, 0, 0);

    // Full / backpressure, then simultaneous enqueue+dequeue on full.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 0, 0, 0);

    // Fence stall with fe_cmd_fence_i high for 5 cycles.
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0, 0);

    // Fence with fe_cmd_fence_i already low: single WAIT cycle.
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 0, 0, 0);

    // Flush over a full FIFO (itlb, fence) with a concurrent redirect.
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0, 0);

    // Reset in the middle of WAIT with two entries queued.
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 300) == 0);
    end

    // Drain.
    repeat (10) drive(0, 0, 0, 1, 0, 0, 0);
    chk("drain_empty", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
